// File: rtl/dmem_pkg.sv
// dmem_pkg: shared arbiter state encoding and width defaults for the data-memory arbiter
package dmem_pkg;
  localparam int AW_DEF       = 32;
  localparam int DW_DEF       = 32;
  localparam int LOCK_MAX_DEF = 15;
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_LOCK0 = 2'd1,
    ARB_LOCK1 = 2'd2
  } arb_state_e;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant decision with an optional fixed owner while the bus is held
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       hold_en,
  input  logic       hold_id,
  output logic [1:0] gnt
);
  // While held only the owner may win; otherwise a lone requester wins and a tie goes to !last
  always_comb begin
    gnt[0] = hold_en ? req[0] & ~hold_id : req[0] & (~req[1] | last);
    gnt[1] = hold_en ? req[1] & hold_id : req[1] & (~req[0] | ~last);
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of the single-port data memory between m0 (core) and m1 (debug/DMA),
// with bus lock for atomic RMW and registered read return. Optional saturating performance counters
// are built when DMEM_ARB_PERF_EN is defined.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_rvalid,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_rvalid,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [15:0]   perf_gnt0,
  output logic [15:0]   perf_gnt1,
  output logic [15:0]   perf_conflict
`endif
);
  localparam int CW = $clog2(LOCK_MAX + 1);

  arb_state_e    state_q, state_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]    arb_gnt, gnt, rvalid_q, rvalid_d;
  logic [DW-1:0] rdata0_q, rdata1_q;
  logic          gid, glock;

  rr_arb2 u_arb (
    .req     ({m1_req, m0_req}),
    .last    (last_q),
    .hold_en (state_q != ARB_IDLE),
    .hold_id (state_q == ARB_LOCK1),
    .gnt     (arb_gnt)
  );

  assign gnt     = rst ? 2'b00 : arb_gnt;
  assign m0_gnt  = gnt[0];
  assign m1_gnt  = gnt[1];
  assign gid     = gnt[1];
  assign glock   = gid ? m1_lock : m0_lock;
  assign cnt_inc = (state_q == ARB_IDLE) ? CW'(1) : cnt_q + CW'(1);

  // Granted master drives the memory; everything is zero when nobody is granted
  always_comb begin
    mem_we    = gnt[0] ? m0_we : gnt[1] & m1_we;
    mem_addr  = gnt[0] ? m0_addr : gnt[1] ? m1_addr : '0;
    mem_wdata = gnt[0] ? m0_wdata : gnt[1] ? m1_wdata : '0;
  end

  // Next state: every grant updates last; locked grants enter or extend the lock until the cap forces release
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (|gnt) begin
      last_d  = gid;
      state_d = (glock && cnt_inc < CW'(LOCK_MAX)) ? (gid ? ARB_LOCK1 : ARB_LOCK0) : ARB_IDLE;
      cnt_d   = (state_d == ARB_IDLE) ? '0 : cnt_inc;
    end
  end

  // Arbitration state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rvalid_d = gnt & ~{m1_we, m0_we};

  // Read return: capture memory data at the grant edge and pulse rvalid for one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      if (rvalid_d[0]) rdata0_q <= mem_rdata;
      if (rvalid_d[1]) rdata1_q <= mem_rdata;
    end
  end

  assign m0_rvalid = rvalid_q[0];
  assign m1_rvalid = rvalid_q[1];
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;

`ifdef DMEM_ARB_PERF_EN
  logic [15:0] perf_gnt0_q, perf_gnt1_q, perf_conflict_q;

  // Saturating grant and contention counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_gnt0_q     <= '0;
      perf_gnt1_q     <= '0;
      perf_conflict_q <= '0;
    end else begin
      perf_gnt0_q     <= perf_gnt0_q + 16'(gnt[0] && perf_gnt0_q != 16'hFFFF);
      perf_gnt1_q     <= perf_gnt1_q + 16'(gnt[1] && perf_gnt1_q != 16'hFFFF);
      perf_conflict_q <= perf_conflict_q + 16'(m0_req && m1_req && perf_conflict_q != 16'hFFFF);
    end
  end

  assign perf_gnt0     = perf_gnt0_q;
  assign perf_gnt1     = perf_gnt1_q;
  assign perf_conflict = perf_conflict_q;
`endif
endmodule
